// File: rtl/inst_queue.sv
// inst_queue: fetch sequencer (ICache request + BTB-steered next PC) feeding a 2**IQ_ADDR_WIDTH entry
// instruction FIFO for the decoder. Build option: define IQ_JAL_PREDECODE_EN to predecode JAL on push.
module inst_queue #(
  parameter int IQ_ADDR_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        IC_req,
  output logic [31:0] IC_PC,
  input  logic        IC_ready,
  input  logic [31:0] IC_inst,
  output logic [31:0] BTB_PC,
  input  logic        BTB_predict,
  input  logic [31:0] BTB_target,
  output logic        IQ_flag,
  output logic [31:0] IQ_inst,
  output logic [31:0] IQ_PC,
  output logic [31:0] IQ_BTB_PC,
  output logic        IQ_BTB_predict,
  input  logic        Dec_flag,
  input  logic        ROB_clear,
  input  logic [31:0] ROB_PC
);

  localparam int DEPTH = 1 << IQ_ADDR_WIDTH;
  localparam logic [IQ_ADDR_WIDTH:0]   CNT_ZERO = {(IQ_ADDR_WIDTH+1){1'b0}};
  localparam logic [IQ_ADDR_WIDTH:0]   CNT_ONE  = {{IQ_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [IQ_ADDR_WIDTH:0]   CNT_FULL = {1'b1, {IQ_ADDR_WIDTH{1'b0}}};
  localparam logic [IQ_ADDR_WIDTH-1:0] PTR_ZERO = {IQ_ADDR_WIDTH{1'b0}};
  localparam logic [IQ_ADDR_WIDTH-1:0] PTR_ONE  = {{(IQ_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                   state_r;
  logic                     ic_req_r;
  logic [31:0]              ic_pc_r;
  logic [31:0]              fetch_pc_r;
  logic [IQ_ADDR_WIDTH-1:0] head_r;
  logic [IQ_ADDR_WIDTH-1:0] tail_r;
  logic [IQ_ADDR_WIDTH:0]   count_r;

  logic [31:0] inst_mem_r [DEPTH];
  logic [31:0] pc_mem_r   [DEPTH];
  logic [31:0] nxt_mem_r  [DEPTH];
  logic        pred_mem_r [DEPTH];

  logic [31:0] nxt_pc_s;
  logic        nxt_pred_s;
  logic        push_s;
  logic        pop_s;
  logic        nonempty_s;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

`ifdef IQ_JAL_PREDECODE_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic logic [31:0] jal_offset(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction
`endif

  // Next fetch PC and stored prediction bit for the instruction returning this cycle.
  always_comb begin
    nxt_pc_s   = seq_pc(fetch_pc_r);
    nxt_pred_s = 1'b0;
`ifdef IQ_JAL_PREDECODE_EN
    if (IC_inst[6:0] == OP_JAL) begin
      nxt_pc_s   = fetch_pc_r + jal_offset(IC_inst);
      nxt_pred_s = 1'b1;
    end else if (BTB_predict) begin
      nxt_pc_s   = BTB_target;
      nxt_pred_s = 1'b1;
    end else begin
      nxt_pc_s   = seq_pc(fetch_pc_r);
      nxt_pred_s = 1'b0;
    end
`else
    if (BTB_predict) begin
      nxt_pc_s   = BTB_target;
      nxt_pred_s = 1'b1;
    end else begin
      nxt_pc_s   = seq_pc(fetch_pc_r);
      nxt_pred_s = 1'b0;
    end
`endif
  end

  // A flush discards both a returning instruction and a decoder pop in the same cycle.
  assign nonempty_s = (count_r != CNT_ZERO);
  assign push_s     = (state_r == S_WAIT) && IC_ready && !ROB_clear;
  assign pop_s      = Dec_flag && nonempty_s && !ROB_clear;

  assign IC_req  = ic_req_r;
  assign IC_PC   = ic_pc_r;
  assign BTB_PC  = fetch_pc_r;
  assign IQ_flag = nonempty_s;

  // Head entry presented to the decoder; zeros while the queue is empty.
  always_comb begin
    if (nonempty_s) begin
      IQ_inst        = inst_mem_r[head_r];
      IQ_PC          = pc_mem_r[head_r];
      IQ_BTB_PC      = nxt_mem_r[head_r];
      IQ_BTB_predict = pred_mem_r[head_r];
    end else begin
      IQ_inst        = 32'h0;
      IQ_PC          = 32'h0;
      IQ_BTB_PC      = 32'h0;
      IQ_BTB_predict = 1'b0;
    end
  end

  // Entry storage; slots are only observed while they lie between head and tail.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push_s) begin
      inst_mem_r[tail_r] <= IC_inst;
      pc_mem_r[tail_r]   <= fetch_pc_r;
      nxt_mem_r[tail_r]  <= nxt_pc_s;
      pred_mem_r[tail_r] <= nxt_pred_s;
    end
  end

  // Fetch FSM, queue pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= S_IDLE;
      ic_req_r   <= 1'b0;
      ic_pc_r    <= 32'h0;
      fetch_pc_r <= 32'h0;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else if (rdy_in) begin
      if (ROB_clear) begin
        state_r    <= S_IDLE;
        ic_req_r   <= 1'b0;
        fetch_pc_r <= ROB_PC;
        head_r     <= PTR_ZERO;
        tail_r     <= PTR_ZERO;
        count_r    <= CNT_ZERO;
      end else begin
        case (state_r)
          S_IDLE: begin
            // Only one request is ever outstanding, so a free slot now guarantees room for its push.
            if (count_r < CNT_FULL) begin
              state_r  <= S_WAIT;
              ic_req_r <= 1'b1;
              ic_pc_r  <= fetch_pc_r;
            end
          end
          S_WAIT: begin
            if (IC_ready) begin
              fetch_pc_r <= nxt_pc_s;
              ic_req_r   <= 1'b0;
              state_r    <= S_IDLE;
            end
          end
          default: begin
            state_r  <= S_IDLE;
            ic_req_r <= 1'b0;
          end
        endcase

        if (push_s) begin
          tail_r <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end

        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
